multicycle_datapath: RTL

- RV32I multicycle datapath that consumes the control word from Control_Unit and returns the current opcode to it.
- Holds PC, old_pc, IR, MDR, A, B, ALUOut, a 32x32 register file, immediate generator, ALU control and ALU.
- Drives a single unified word memory with combinational read data (mem_rdata is valid in the same cycle as mem_addr).

---
 rtl/multicycle_datapath.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// RV32I multicycle datapath: architectural state, register file, immediate
// generator and ALU. Sequencing comes from an external control unit; this
// block only reports the current opcode back to it.
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              ir_write,
  input  logic              pc_source,
  input  logic              reg_write,
  input  logic              memory_read,
  input  logic              is_immediate,
  input  logic              memory_write,
  input  logic              pc_write_cond,
  input  logic              lorD,
  input  logic              memory_to_reg,
  input  logic [1:0]        aluop,
  input  logic [1:0]        alu_src_a,
  input  logic [1:0]        alu_src_b,
  output logic [6:0]        instruction_opcode,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] pc_out
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Architectural and inter-cycle registers
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] old_pc_q, old_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic [DATA_W-1:0] rf_q [32];

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7_5 = ir_q[30];
  assign rs1      = ir_q[19:15];
  assign rs2      = ir_q[24:20];
  assign rd       = ir_q[11:7];

  // Datapath intermediates
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;
  logic              branch_taken;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] next_pc_raw;
  logic [DATA_W-1:0] next_pc;
  logic              pc_en;
  logic [DATA_W-1:0] wb_data;
  logic              rf_we;

  assign shamt = operand_b[4:0];

  // Immediate generation, format chosen by the latched opcode
  always_comb begin
    imm = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_STORE:                 imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:                imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                                       ir_q[30:25], ir_q[11:8], 1'b0};
      OP_AUIPC, OP_LUI:         imm = {ir_q[31:12], 12'b0};
      OP_JAL:                   imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                                       ir_q[20], ir_q[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

  // ALU operand multiplexers
  always_comb begin
    operand_a = '0;
    case (alu_src_a)
      2'b00:   operand_a = pc_q;
      2'b01:   operand_a = a_q;
      2'b10:   operand_a = old_pc_q;
      default: operand_a = '0;
    endcase
    operand_b = '0;
    case (alu_src_b)
      2'b00:   operand_b = b_q;
      2'b01:   operand_b = 32'd4;
      2'b10:   operand_b = imm;
      default: operand_b = '0;
    endcase
  end

  // ALU control and ALU; branch_taken is only meaningful for the compare class
  always_comb begin
    alu_result   = operand_a + operand_b;
    branch_taken = 1'b0;
    case (aluop)
      2'b01: begin
        alu_result = operand_a - operand_b;
        case (funct3)
          3'b000:  branch_taken = (operand_a == operand_b);
          3'b001:  branch_taken = (operand_a != operand_b);
          3'b100:  branch_taken = ($signed(operand_a) <  $signed(operand_b));
          3'b101:  branch_taken = ($signed(operand_a) >= $signed(operand_b));
          3'b110:  branch_taken = (operand_a <  operand_b);
          3'b111:  branch_taken = (operand_a >= operand_b);
          default: branch_taken = 1'b0;
        endcase
      end
      2'b10: begin
        case (funct3)
          3'b000: begin
            // Immediate forms reuse bit 30 as immediate data, so only R-type subtracts
            if (funct7_5 && !is_immediate) alu_result = operand_a - operand_b;
            else                           alu_result = operand_a + operand_b;
          end
          3'b001:  alu_result = operand_a << shamt;
          3'b010:  alu_result = {31'b0, ($signed(operand_a) < $signed(operand_b))};
          3'b011:  alu_result = {31'b0, (operand_a < operand_b)};
          3'b100:  alu_result = operand_a ^ operand_b;
          3'b101: begin
            if (funct7_5) alu_result = $unsigned($signed(operand_a) >>> shamt);
            else          alu_result = operand_a >> shamt;
          end
          3'b110:  alu_result = operand_a | operand_b;
          default: alu_result = operand_a & operand_b;
        endcase
      end
      default: alu_result = operand_a + operand_b;
    endcase
  end

  // Next-PC selection; JALR targets always have bit 0 cleared
  always_comb begin
    next_pc_raw = pc_source ? aluout_q : alu_result;
    next_pc     = next_pc_raw;
    if (opcode == OP_JALR) next_pc[0] = 1'b0;
    pc_en = pc_write | (pc_write_cond & branch_taken);
  end

  // Next-state values for the inter-cycle registers
  always_comb begin
    pc_d     = pc_en ? next_pc : pc_q;
    ir_d     = ir_write ? mem_rdata : ir_q;
    old_pc_d = ir_write ? pc_q : old_pc_q;
    mdr_d    = (memory_read & lorD) ? mem_rdata : mdr_q;
    a_d      = rf_q[rs1];
    b_d      = rf_q[rs2];
    aluout_d = alu_result;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      old_pc_q <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Register file write-back; x0 never takes a write
  assign wb_data = memory_to_reg ? mdr_q : aluout_q;
  assign rf_we   = reg_write && (rd != 5'd0);

  // Register file storage; must clear on reset, so it is built from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= wb_data;
    end
  end

  // Memory interface and status outputs
  assign instruction_opcode = opcode;
  assign mem_addr           = lorD ? aluout_q : pc_q;
  assign mem_wdata          = b_q;
  assign mem_re             = memory_read;
  assign mem_we             = memory_write;
  assign pc_out             = pc_q;

endmodule
